// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer for the fetch stage, trained from M.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update to the fetch lookup.
module branch_target_buffer #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        pcsrcPF,
  output logic        hitF,
  output logic [31:0] targetF,
  output logic [31:0] next_pcF,
  input  logic        branchM,
  input  logic        pcsrcM,
  input  logic [31:0] pcM,
  input  logic [31:0] targetM
);
  localparam int unsigned SETS = 1 << INDEX_BITS;

  logic [1:0]          validQ  [SETS];
  logic [TAG_BITS-1:0] tagQ    [SETS][2];
  logic [29:0]         targetQ [SETS][2];
  logic [SETS-1:0]     lruQ;

  logic [INDEX_BITS-1:0] idxF, idxM;
  logic [TAG_BITS-1:0]   tagF, tagM;
  logic                  matchF0, matchF1, matchM0, matchM1;
  logic                  updateM, wayM;
  logic                  unusedBits;

  assign idxF = pcF[INDEX_BITS+1:2];
  assign tagF = pcF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign idxM = pcM[INDEX_BITS+1:2];
  assign tagM = pcM[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  assign unusedBits = ^{pcF[31:INDEX_BITS+TAG_BITS+2], pcF[1:0],
                        pcM[31:INDEX_BITS+TAG_BITS+2], pcM[1:0], targetM[1:0]};

  assign updateM = branchM & pcsrcM;

  assign matchF0 = validQ[idxF][0] && (tagQ[idxF][0] == tagF);
  assign matchF1 = validQ[idxF][1] && (tagQ[idxF][1] == tagF);
  assign matchM0 = validQ[idxM][0] && (tagQ[idxM][0] == tagM);
  assign matchM1 = validQ[idxM][1] && (tagQ[idxM][1] == tagM);

  always_comb begin
    hitF    = matchF0 | matchF1;
    targetF = 32'h0;
    if (matchF0) begin
      targetF = {targetQ[idxF][0], 2'b00};
    end else if (matchF1) begin
      targetF = {targetQ[idxF][1], 2'b00};
    end
`ifdef BTB_BYPASS_EN
    if (updateM && (idxM == idxF) && (tagM == tagF)) begin
      hitF    = 1'b1;
      targetF = {targetM[31:2], 2'b00};
    end
`endif
    next_pcF = (hitF && pcsrcPF) ? targetF : pcF + 32'd4;
  end

  // Way choice: matching way, else lowest invalid way, else the LRU way.
  always_comb begin
    wayM = lruQ[idxM];
    if (matchM0) begin
      wayM = 1'b0;
    end else if (matchM1) begin
      wayM = 1'b1;
    end else if (!validQ[idxM][0]) begin
      wayM = 1'b0;
    end else if (!validQ[idxM][1]) begin
      wayM = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        validQ[i] <= 2'b00;
      end
      lruQ <= '0;
    end else if (updateM) begin
      validQ[idxM][wayM] <= 1'b1;
      lruQ[idxM]         <= ~wayM;
    end
  end

  // Tag and target storage needs no reset; validity gates every use.
  always_ff @(posedge clk) begin
    if (!rst && updateM) begin
      tagQ[idxM][wayM]    <= tagM;
      targetQ[idxM][wayM] <= targetM[31:2];
    end
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- 2-way set-associative Branch Target Buffer in the fetch stage, alongside the tournament direction predictor.
- Combinationally supplies the predicted target for the current fetch PC and selects the next PC, using the direction bit pcsrcPF from the predictor.
- Trained from the M stage with resolved branch outcome and target, at the same point the direction predictor updates.

Parameters:
- INDEX_BITS, 4, set index width; SETS = 1<<INDEX_BITS.
- TAG_BITS, 10, stored tag width (partial tag).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pcF  in  32  fetch-stage PC
- pcsrcPF  in  1  predicted direction from direction predictor (1 = taken)
- hitF  out  1  BTB hit for pcF
- targetF  out  32  predicted target; 0 when hitF = 0
- next_pcF  out  32  targetF if (hitF & pcsrcPF), else pcF+4
- branchM  in  1  M-stage instruction is a branch/jump
- pcsrcM  in  1  resolved direction (1 = taken)
- pcM  in  32  M-stage branch PC
- targetM  in  32  resolved taken target

Behaviour:
- Field split:
  - idx = pc[INDEX_BITS+1:2]
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
  - pc[1:0] ignored
- Storage per set:
  - 2 ways, each holding valid bit, TAG_BITS tag and 30-bit target; target[1:0] is implied 00.
  - One LRU bit per set naming the way to replace next.
- Lookup (purely combinational, zero latency):
  - hitF = 1 if either way of set idx(pcF) is valid with a matching tag.
  - If both ways match (must not happen; guarded by update rule), way 0 wins.
- Update (registered at the posedge when branchM & pcsrcM):
  - Hit in set idx(pcM): overwrite that way's target with targetM[31:2]; LRU <= other way.
  - Miss, some way invalid: allocate the lowest-numbered invalid way with valid=1, tag, target; LRU <= other way.
  - Miss, both valid: replace way LRU; LRU <= other way.
- branchM & !pcsrcM: no state change; entries are not invalidated on not-taken.
- branchM = 0: no state change regardless of the other M inputs.
- Read-during-write (same cycle lookup and update to the same set): lookup returns pre-update contents unless BTB_BYPASS_EN is defined.
- Reset:
  - All valid bits and LRU bits clear to 0; targets and tags are don't-care.
  - Outputs after reset: hitF = 0, targetF = 0, next_pcF = pcF+4.
  - Reset asserted mid-operation wins over a coincident update; the update is discarded.
- Arithmetic: pcF+4 wraps modulo 2^32, so 0xFFFFFFFC goes to 0x00000000.
- No flush or stall inputs. A flushed M instruction must present branchM = 0.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: when an update is active this cycle (branchM & pcsrcM) and the full tag and idx of pcM equal those of pcF:
  - hitF = 1, targetF = {targetM[31:2],2'b00}, next_pcF follows the rule above.
  - Forwarding is combinational; stored state is unchanged versus the non-bypass build.
- Undefined: no forwarding path; lookup sees array contents only.

Test Plan:
- Reset, then pcF=0x00400010 with pcsrcPF=1 -> hitF=0, targetF=0, next_pcF=0x00400014.
- Update pcM=0x00400010, targetM=0x00400100, taken; next cycle pcF=0x00400010, pcsrcPF=1 -> hitF=1, next_pcF=0x00400100. Same with pcsrcPF=0 -> next_pcF=0x00400014.
- LRU eviction: with INDEX_BITS=4, take updates A=0x00400010, B=0x00401010, C=0x00402010 (same idx 4) in order -> A evicted (miss), B and C hit; then re-touch B and insert A -> C evicted.
- Not-taken: after allocating A, issue branchM=1, pcsrcM=0 for pcM=A -> A still hits with the old target. Taken update with a new target 0x00400200 -> targetF=0x00400200, no second way allocated.
- Same-cycle update and lookup of A (fresh): without the macro -> hitF=0 that cycle, 1 next cycle. With BTB_BYPASS_EN -> hitF=1 and targetF=targetM in the same cycle.
- Reset mid-operation: rst=1 coincident with a taken update -> after release, every prior entry and the coincident one miss. Also pcF=0xFFFFFFFC on a miss -> next_pcF=0x00000000.
